// File: rtl/bidirectional_piso_serializer_pkg.sv
// Shared definitions for the bidirectional PISO serializer and its
// receiver-side counterpart (the bidirectional serial-in shift register).
//   state_e       : two-state transmit FSM encoding
//   DIR_*         : bit-order select values carried on the dir input
package bidirectional_piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;  // shift left, shreg[N-1] on the wire
  localparam logic DIR_LSB_FIRST = 1'b1;  // shift right, shreg[0] on the wire

endpackage

// File: rtl/bidirectional_piso_serializer.sv
// Parallel-in, serial-out transmitter with per-word selectable bit order.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   load_valid/ready : parallel word handshake (accept = valid && ready)
//   load_data, dir   : word and bit order, sampled only on accept
//   so, so_valid     : serial bit and its qualifier
//   so_last          : marks the final bit of the word
//   busy             : a word is being shifted
module bidirectional_piso_serializer
  import bidirectional_piso_serializer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  input  logic         dir,
  output logic         so,
  output logic         so_valid,
  output logic         so_last,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic           dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic last_bit;
  logic accept;

  assign last_bit   = (state_q == SHIFT) && (cnt_q == CNT_MAX);
  // Ready on the last bit as well, so a new word can follow with no gap.
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_data;
      dir_d   = dir;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = (dir_q == DIR_LSB_FIRST) ? {1'b0, shreg_q[N-1:1]}
                                           : {shreg_q[N-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dir_q   <= DIR_MSB_FIRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign so_valid = busy;
  assign so_last  = last_bit;
  assign so       = busy && ((dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[N-1]);

endmodule

// File: tb/tb_bidirectional_piso_serializer.sv
// Directed bench for bidirectional_piso_serializer (N=4). Expected serial
// sequences are hand-derived; a small behavioural receiver reassembles the
// stream to confirm loopback in both bit orders.
module tb_bidirectional_piso_serializer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_data;
  logic       dir;
  logic       so;
  logic       so_valid;
  logic       so_last;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic       rx_dir;
  logic [3:0] rx_q;

  bidirectional_piso_serializer #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .dir        (dir),
    .so         (so),
    .so_valid   (so_valid),
    .so_last    (so_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: 1 = LSB-first (bits enter at the top), 0 = MSB-first.
  always @(posedge clk) begin
    if (so_valid) begin
      if (rx_dir) rx_q <= {so, rx_q[3:1]};
      else        rx_q <= {rx_q[2:0], so};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic r);
    load_valid = 1'b1;
    load_data  = d;
    dir        = r;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Called at cycle 1 of a word. seq[3] is the bit expected on cycle 1.
  task automatic run_word(input logic [3:0] seq, input bit poke, input bit chain,
                          input logic [3:0] nd, input logic nr, input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_so%0d", tag, i), so, seq[3-i]);
      chk($sformatf("%s_vld%0d", tag, i), so_valid, 1);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      chk($sformatf("%s_last%0d", tag, i), so_last, (i == 3));
      chk($sformatf("%s_rdy%0d", tag, i), load_ready, (i == 3));
      if (poke && i == 1) begin
        load_valid = 1'b1;
        load_data  = 4'b0110;
        dir        = ~dir;
      end
      if (chain && i == 3) begin
        load_valid = 1'b1;
        load_data  = nd;
        dir        = nr;
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      if (!poke) load_data = 4'hF;  // mid-word changes must not matter
    end
    if (!chain) begin
      chk({tag, "_idle_so"}, so, 0);
      chk({tag, "_idle_vld"}, so_valid, 0);
      chk({tag, "_idle_rdy"}, load_ready, 1);
    end
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 4'h0;
    dir        = 1'b0;
    rx_dir     = 1'b0;
    #3;
    chk("rst_so", so, 0);
    chk("rst_vld", so_valid, 0);
    chk("rst_last", so_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", load_ready, 1);
    #9 rst = 1'b1;  // released between edges
    @(posedge clk); #1;

    // LSB-first 1011 -> 1,1,0,1
    send(4'b1011, 1'b1);
    run_word(4'b1101, 0, 0, 4'h0, 1'b0, "lsb");

    // MSB-first 1011 -> 1,0,1,1
    send(4'b1011, 1'b0);
    run_word(4'b1011, 0, 0, 4'h0, 1'b0, "msb");

    // Back-to-back: 1100 MSB then 0011 LSB -> 1,1,0,0,1,1,0,0
    send(4'b1100, 1'b0);
    run_word(4'b1100, 0, 1, 4'b0011, 1'b1, "b2b_a");
    run_word(4'b1100, 0, 0, 4'h0, 1'b0, "b2b_b");

    // Load attempt while busy is ignored: 1001 LSB -> 1,0,0,1
    send(4'b1001, 1'b1);
    run_word(4'b1001, 1, 0, 4'h0, 1'b0, "busy");

    // Reset mid-word: 1100 MSB has a 1 on cycle 2, so the drop is visible.
    send(4'b1100, 1'b0);
    @(posedge clk); #1;
    chk("mid_pre_so", so, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_so", so, 0);
    chk("mid_vld", so_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_last", so_last, 0);
    chk("mid_rdy", load_ready, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    send(4'b0101, 1'b1);
    run_word(4'b1010, 0, 0, 4'h0, 1'b0, "post_rst");

    // Loopback through the receiver model, both orders.
    rx_dir = 1'b1;
    send(4'b1101, 1'b1);
    run_word(4'b1011, 0, 0, 4'h0, 1'b0, "lb_lsb");
    chk("lb_lsb_q", rx_q, 4'b1101);
    rx_dir = 1'b0;
    send(4'b0110, 1'b0);
    run_word(4'b0110, 0, 0, 4'h0, 1'b0, "lb_msb");
    chk("lb_msb_q", rx_q, 4'b0110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bidirectional_piso_serializer.md
Name: bidirectional_piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the counterpart of the team's serial-in bidirectional shift register.
- Accepts an N-bit word over a valid/ready load handshake and shifts it out one bit per clock.
- Bit order is selectable per word: LSB-first (right shift) or MSB-first (left shift). A receiver running the same direction reconstructs the word.
- Sits between a parallel data source and a single-wire serial link.

Parameters:
- N, 4, word width in bits; legal range N >= 2.
- CNT_W, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
- load_valid  input  1  source offers load_data/dir this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  N  parallel word to transmit.
- dir  input  1  1 = LSB-first (shift right), 0 = MSB-first (shift left); sampled only at acceptance.
- so  output  1  serial data out.
- so_valid  output  1  so carries a frame bit this cycle.
- so_last  output  1  current so bit is the final bit of the word.
- busy  output  1  high while a word is being shifted.

Behaviour:
- States: IDLE, SHIFT.
- Internal registers: shreg[N-1:0], dir_q, cnt[CNT_W-1:0].
- Reset (rst=0, asynchronous): state=IDLE, shreg=0, dir_q=0, cnt=0.
  - All outputs while in reset: so=0, so_valid=0, so_last=0, busy=0, load_ready=1.
- Accept = load_valid && load_ready, evaluated at posedge.
  - On accept: shreg<=load_data, dir_q<=dir, cnt<=0, state<=SHIFT.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==N-1).
  - It depends only on state, never on load_valid.
- Output decode (combinational from registers):
  - so = dir_q ? shreg[0] : shreg[N-1], gated to 0 in IDLE.
  - so_valid = busy = (state==SHIFT).
  - so_last = (state==SHIFT && cnt==N-1).
- Latency: the first bit appears on so in the cycle after the accepting edge. The word occupies exactly N consecutive so_valid cycles.
- Each posedge in SHIFT with cnt<N-1:
  - dir_q=1: shreg<={1'b0, shreg[N-1:1]}.
  - dir_q=0: shreg<={shreg[N-2:0], 1'b0}.
  - cnt<=cnt+1.
- Posedge in SHIFT with cnt==N-1 (last bit):
  - If accept: reload as above and stay in SHIFT. This gives back-to-back words with no idle gap.
  - Otherwise: state<=IDLE, cnt<=0, shreg<=0.
- load_valid while load_ready=0 is ignored; the source must hold the word until ready.
- Changes on dir or load_data mid-word have no effect on the word in flight.
- Reset asserted mid-word aborts it immediately: outputs go to reset values asynchronously and no partial completion is signalled. After reset release, the first posedge may accept a new word.
- No arithmetic overflow is possible: cnt never exceeds N-1.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, SHIFT};
  - direction constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1, shared with the receiver-side shift register bench.
- CNT_W stays a localparam in the module (it is N-dependent).
- Single module; no sub-module is warranted. Shifter, counter and two-state FSM are small enough to keep inline.

Test Plan:
- N=4. Reset, then load 4'b1011 with dir=1. Required: so = 1,1,0,1 on cycles 1-4 after accept; so_valid high for those 4 cycles; so_last only on cycle 4; then IDLE with so=0.
- Load 4'b1011 with dir=0. Required: so = 1,0,1,1; load_ready=0 on cycles 1-3 and 1 on cycle 4.
- Back-to-back: 4'b1100 (dir=0), then 4'b0011 (dir=1) accepted on the so_last cycle. Required: so = 1,1,0,0,1,1,0,0 contiguous; so_valid never drops between words.
- Busy protection: during word 4'b1001 (dir=1), pulse load_valid with 4'b0110 on cycle 2 and toggle dir. Required: ignored; output stays 1,0,0,1.
- Reset mid-word: assert rst=0 between clock edges on cycle 2 of a word. Required: so, so_valid, busy go to 0 before the next edge; load_ready=1. After release, a new word 4'b0101 (dir=1) serializes as 1,0,1,0.
- Receiver loopback: drive so into the bidirectional shift register with matching direction for 4 cycles. Required: its q equals load_data for both directions.
